// File: rtl/hc_csr_bank.sv
// hc_csr_bank: MMIO control/status register bank for HardCloud AFUs.
// Two-stage pipeline: request capture, then register update and read response.
module hc_csr_bank #(
    parameter int unsigned  NUM_BUFFERS  = 4,
    parameter int unsigned  NUM_COUNTERS = 4,
    parameter int unsigned  CNT_W        = 48,
    parameter int unsigned  ADDR_W       = 42,
    parameter logic [127:0] AFU_ID       = 128'hC000C966_0D82_4272_9AEF_FE5F84570612
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          mmio_rd_valid,
    input  logic                          mmio_wr_valid,
    input  logic [15:0]                   mmio_addr,
    input  logic [8:0]                    mmio_tid,
    input  logic [63:0]                   mmio_wdata,
    output logic                          mmio_rsp_valid,
    output logic [8:0]                    mmio_rsp_tid,
    output logic [63:0]                   mmio_rsp_data,
    output logic [31:0]                   hc_control,
    output logic                          hc_start,
    output logic [ADDR_W-1:0]             hc_dsm_base,
    output logic [NUM_BUFFERS*ADDR_W-1:0] hc_buf_addr,
    output logic [NUM_BUFFERS*32-1:0]     hc_buf_size,
    input  logic [63:0]                   hc_status,
    input  logic [NUM_COUNTERS-1:0]       cnt_event
);

    localparam logic [63:0] DFH = 64'h1000_0000_0400_0000;

    // 64-bit register index (byte offset >> 3) within the 0x000-0x1FF window
    localparam logic [5:0] Q_DFH     = 6'd0;
    localparam logic [5:0] Q_ID_L    = 6'd1;
    localparam logic [5:0] Q_ID_H    = 6'd2;
    localparam logic [5:0] Q_SCRATCH = 6'd5;
    localparam logic [5:0] Q_CONTROL = 6'd6;
    localparam logic [5:0] Q_STATUS  = 6'd7;
    localparam logic [5:0] Q_DSM     = 6'd8;

    logic                           s1_rd;
    logic                           s1_wr;
    logic [5:0]                     s1_qidx;
    logic [8:0]                     s1_tid;
    logic [63:0]                    s1_wdata;
    logic                           in_window;
    logic                           unused_addr_lsb;

    logic [63:0]                    scratch;
    logic [63:0]                    rd_data;
    logic [NUM_COUNTERS*CNT_W-1:0]  cnt_flat;

    assign in_window       = (mmio_addr[15:7] == '0);
    assign unused_addr_lsb = mmio_addr[0];

    // Stage 1: capture the request; out-of-window requests never enter the pipe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_rd    <= 1'b0;
            s1_wr    <= 1'b0;
            s1_qidx  <= '0;
            s1_tid   <= '0;
            s1_wdata <= '0;
        end else begin
            s1_rd    <= mmio_rd_valid && in_window;
            s1_wr    <= mmio_wr_valid && in_window;
            s1_qidx  <= mmio_addr[6:1];
            s1_tid   <= mmio_tid;
            s1_wdata <= mmio_wdata;
        end
    end

    // Stage 2: scalar register updates
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scratch     <= '0;
            hc_control  <= '0;
            hc_dsm_base <= '0;
            hc_start    <= 1'b0;
        end else begin
            hc_start <= s1_wr && (s1_qidx == Q_CONTROL) && s1_wdata[0];
            if (s1_wr) begin
                if (s1_qidx == Q_SCRATCH) scratch     <= s1_wdata;
                if (s1_qidx == Q_CONTROL) hc_control  <= s1_wdata[31:0];
                if (s1_qidx == Q_DSM)     hc_dsm_base <= s1_wdata[ADDR_W+5:6];
            end
        end
    end

    // Buffer descriptors: address at 0x100+16*i, size at 0x108+16*i
    for (genvar g = 0; g < NUM_BUFFERS; g++) begin : g_buf
        localparam logic [5:0] QA = 6'(32 + 2*g);
        localparam logic [5:0] QS = 6'(33 + 2*g);
        logic [ADDR_W-1:0] baddr;
        logic [31:0]       bsize;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                baddr <= '0;
                bsize <= '0;
            end else if (s1_wr) begin
                if (s1_qidx == QA) baddr <= s1_wdata[ADDR_W+5:6];
                if (s1_qidx == QS) bsize <= s1_wdata[31:0];
            end
        end

        assign hc_buf_addr[g*ADDR_W +: ADDR_W] = baddr;
        assign hc_buf_size[g*32 +: 32]         = bsize;
    end

    // Event counters at 0x080+8*i; a write clears and takes priority over an event
    for (genvar g = 0; g < NUM_COUNTERS; g++) begin : g_cnt
        localparam logic [5:0] QC = 6'(16 + g);
        logic [CNT_W-1:0] cnt;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt <= '0;
            end else if (s1_wr && (s1_qidx == QC)) begin
                cnt <= '0;
            end else if (cnt_event[g]) begin
                cnt <= cnt + CNT_W'(1);
            end
        end

        assign cnt_flat[g*CNT_W +: CNT_W] = cnt;
    end

    // Read mux sees pre-update values, so a same-cycle write is not reflected
    always_comb begin
        rd_data = '0;
        case (s1_qidx)
            Q_DFH:     rd_data = DFH;
            Q_ID_L:    rd_data = AFU_ID[63:0];
            Q_ID_H:    rd_data = AFU_ID[127:64];
            Q_SCRATCH: rd_data = scratch;
            Q_CONTROL: rd_data = {32'h0, hc_control};
            Q_STATUS:  rd_data = hc_status;
            Q_DSM:     rd_data = 64'(hc_dsm_base) << 6;
            default:   rd_data = '0;
        endcase
        for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
            if (s1_qidx == 6'(16 + i)) rd_data = 64'(cnt_flat[i*CNT_W +: CNT_W]);
        end
        for (int unsigned i = 0; i < NUM_BUFFERS; i++) begin
            if (s1_qidx == 6'(32 + 2*i)) rd_data = 64'(hc_buf_addr[i*ADDR_W +: ADDR_W]) << 6;
            if (s1_qidx == 6'(33 + 2*i)) rd_data = {32'h0, hc_buf_size[i*32 +: 32]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mmio_rsp_valid <= 1'b0;
            mmio_rsp_tid   <= '0;
            mmio_rsp_data  <= '0;
        end else begin
            mmio_rsp_valid <= s1_rd;
            if (s1_rd) begin
                mmio_rsp_tid  <= s1_tid;
                mmio_rsp_data <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_hc_csr_bank.sv
// Self-checking bench for hc_csr_bank: directed scenarios plus randomized
// read/write traffic against a byte-offset based reference model.
module tb_hc_csr_bank;

    localparam int NB    = 4;
    localparam int NC    = 4;
    localparam int CW    = 48;
    localparam int AW    = 42;
    localparam int NRAND = 300;

    localparam logic [63:0] DFH_V = 64'h1000_0000_0400_0000;
    localparam logic [63:0] ID_LO = 64'h9AEF_FE5F_8457_0612;
    localparam logic [63:0] ID_HI = 64'hC000_C966_0D82_4272;

    logic               clk = 1'b0;
    logic               reset;
    logic               mmio_rd_valid;
    logic               mmio_wr_valid;
    logic [15:0]        mmio_addr;
    logic [8:0]         mmio_tid;
    logic [63:0]        mmio_wdata;
    logic               mmio_rsp_valid;
    logic [8:0]         mmio_rsp_tid;
    logic [63:0]        mmio_rsp_data;
    logic [31:0]        hc_control;
    logic               hc_start;
    logic [AW-1:0]      hc_dsm_base;
    logic [NB*AW-1:0]   hc_buf_addr;
    logic [NB*32-1:0]   hc_buf_size;
    logic [63:0]        hc_status;
    logic [NC-1:0]      cnt_event;

    hc_csr_bank #(
        .NUM_BUFFERS (NB),
        .NUM_COUNTERS(NC),
        .CNT_W       (CW),
        .ADDR_W      (AW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mmio_rd_valid (mmio_rd_valid),
        .mmio_wr_valid (mmio_wr_valid),
        .mmio_addr     (mmio_addr),
        .mmio_tid      (mmio_tid),
        .mmio_wdata    (mmio_wdata),
        .mmio_rsp_valid(mmio_rsp_valid),
        .mmio_rsp_tid  (mmio_rsp_tid),
        .mmio_rsp_data (mmio_rsp_data),
        .hc_control    (hc_control),
        .hc_start      (hc_start),
        .hc_dsm_base   (hc_dsm_base),
        .hc_buf_addr   (hc_buf_addr),
        .hc_buf_size   (hc_buf_size),
        .hc_status     (hc_status),
        .cnt_event     (cnt_event)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state, addressed by byte offset
    logic [63:0]    m_scratch;
    logic [31:0]    m_control;
    logic [63:0]    m_dsm;
    logic [63:0]    m_baddr [NB];
    logic [31:0]    m_bsize [NB];
    longint unsigned m_cnt  [NC];
    logic [63:0]    m_status;

    function automatic void model_reset();
        m_scratch = '0;
        m_control = '0;
        m_dsm     = '0;
        for (int i = 0; i < NB; i++) begin
            m_baddr[i] = '0;
            m_bsize[i] = '0;
        end
        for (int i = 0; i < NC; i++) m_cnt[i] = 0;
    endfunction

    function automatic int unsigned byte_off(input logic [15:0] dw);
        return {14'b0, dw, 2'b00} & 32'hFFFF_FFF8;
    endfunction

    function automatic void model_write(input logic [15:0] dw, input logic [63:0] d);
        int unsigned off;
        int unsigned i;
        logic [63:0] amask;
        off   = byte_off(dw);
        amask = (64'd1 << AW) - 64'd1;
        if (off >= 'h200) return;
        if (off == 'h28) m_scratch = d;
        else if (off == 'h30) m_control = d[31:0];
        else if (off == 'h40) m_dsm = (d >> 6) & amask;
        else if (off >= 'h80 && off < 'h100) begin
            i = (off - 'h80) / 8;
            if (i < NC) m_cnt[i] = 0;
        end else if (off >= 'h100) begin
            i = (off - 'h100) / 16;
            if (i < NB) begin
                if (off % 16 == 0) m_baddr[i] = (d >> 6) & amask;
                else               m_bsize[i] = d[31:0];
            end
        end
    endfunction

    function automatic void model_read(input logic [15:0] dw, output logic v, output logic [63:0] d);
        int unsigned off;
        int unsigned i;
        off = byte_off(dw);
        v   = (off < 'h200);
        d   = '0;
        if (off == 'h00) d = DFH_V;
        else if (off == 'h08) d = ID_LO;
        else if (off == 'h10) d = ID_HI;
        else if (off == 'h28) d = m_scratch;
        else if (off == 'h30) d = {32'h0, m_control};
        else if (off == 'h38) d = m_status;
        else if (off == 'h40) d = m_dsm << 6;
        else if (off >= 'h80 && off < 'h100) begin
            i = (off - 'h80) / 8;
            if (i < NC) d = 64'(m_cnt[i]) & ((64'd1 << CW) - 64'd1);
        end else if (off >= 'h100 && off < 'h200) begin
            i = (off - 'h100) / 16;
            if (i < NB) d = (off % 16 == 0) ? (m_baddr[i] << 6) : {32'h0, m_bsize[i]};
        end
    endfunction

    // Issue a read at the current negedge; sample the response slot two cycles later
    task automatic single_read(input logic [15:0] dw, input logic [8:0] tid,
                               output logic v, output logic [8:0] t, output logic [63:0] d);
        mmio_addr     = dw;
        mmio_tid      = tid;
        mmio_rd_valid = 1'b1;
        @(negedge clk);
        mmio_rd_valid = 1'b0;
        @(negedge clk);
        v = mmio_rsp_valid;
        t = mmio_rsp_tid;
        d = mmio_rsp_data;
    endtask

    task automatic single_write(input logic [15:0] dw, input logic [63:0] d);
        mmio_addr     = dw;
        mmio_wdata    = d;
        mmio_wr_valid = 1'b1;
        @(negedge clk);
        mmio_wr_valid = 1'b0;
        @(negedge clk);
        model_write(dw, d);
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        mmio_rd_valid = 1'b0;
        mmio_wr_valid = 1'b0;
        mmio_addr     = '0;
        mmio_tid      = '0;
        mmio_wdata    = '0;
        hc_status     = 64'h0123_4567_89AB_CDEF;
        m_status      = hc_status;
        cnt_event     = '0;
        model_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (mmio_rsp_valid !== 1'b0 || mmio_rsp_tid !== '0 || mmio_rsp_data !== '0) begin
            n_err++;
            $display("FAIL reset_rsp: got valid=%0b tid=%0d data=%h, want 0", mmio_rsp_valid, mmio_rsp_tid, mmio_rsp_data);
        end
        n_cmp++;
        if (hc_control !== '0 || hc_start !== 1'b0 || hc_dsm_base !== '0 || hc_buf_addr !== '0 || hc_buf_size !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got ctrl=%h start=%0b dsm=%h baddr=%h bsize=%h, want 0",
                     hc_control, hc_start, hc_dsm_base, hc_buf_addr, hc_buf_size);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Four reads on consecutive cycles; each response must land exactly two cycles later
    task automatic test_id_regs();
        logic [15:0] addrs [4];
        logic [63:0] exps  [4];
        addrs = '{16'h00, 16'h02, 16'h04, 16'h06};
        exps  = '{DFH_V, ID_LO, ID_HI, 64'h0};
        for (int k = 0; k < 6; k++) begin
            if (k >= 2) begin
                n_cmp++;
                if (mmio_rsp_valid !== 1'b1 || mmio_rsp_tid !== 9'(k - 1) || mmio_rsp_data !== exps[k-2]) begin
                    n_err++;
                    $display("FAIL id_read[%0d]: got valid=%0b tid=%0d data=%h, want valid=1 tid=%0d data=%h",
                             k - 2, mmio_rsp_valid, mmio_rsp_tid, mmio_rsp_data, k - 1, exps[k-2]);
                end
            end
            if (k < 4) begin
                mmio_addr     = addrs[k];
                mmio_tid      = 9'(k + 1);
                mmio_rd_valid = 1'b1;
            end else begin
                mmio_rd_valid = 1'b0;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (mmio_rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL id_tail: got valid=%0b, want 0", mmio_rsp_valid);
        end
    endtask

    task automatic test_buf_raw();
        mmio_addr     = 16'h48;
        mmio_wdata    = 64'h1234_5678_9AC0;
        mmio_wr_valid = 1'b1;
        @(negedge clk);
        model_write(16'h48, 64'h1234_5678_9AC0);
        mmio_wr_valid = 1'b0;
        mmio_tid      = 9'd7;
        mmio_rd_valid = 1'b1;
        @(negedge clk);
        mmio_rd_valid = 1'b0;
        n_cmp++;
        if (hc_buf_addr[2*AW +: AW] !== 42'h48_D159_E26B) begin
            n_err++;
            $display("FAIL buf_addr_out: got %h, want %h", hc_buf_addr[2*AW +: AW], 42'h48_D159_E26B);
        end
        @(negedge clk);
        n_cmp++;
        if (mmio_rsp_valid !== 1'b1 || mmio_rsp_tid !== 9'd7 || mmio_rsp_data !== 64'h1234_5678_9AC0) begin
            n_err++;
            $display("FAIL buf_raw_read: got valid=%0b tid=%0d data=%h, want valid=1 tid=7 data=%h",
                     mmio_rsp_valid, mmio_rsp_tid, mmio_rsp_data, 64'h1234_5678_9AC0);
        end
    endtask

    task automatic test_control_start();
        logic exp_start [6];
        exp_start = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        mmio_addr  = 16'h0C;
        mmio_wdata = 64'h5;
        for (int k = 0; k < 6; k++) begin
            mmio_wr_valid = (k == 0 || k == 2);
            @(negedge clk);
            n_cmp++;
            if (hc_start !== exp_start[k]) begin
                n_err++;
                $display("FAIL start_pulse[T+%0d]: got %0b, want %0b", k + 1, hc_start, exp_start[k]);
            end
        end
        model_write(16'h0C, 64'h5);
        n_cmp++;
        if (hc_control !== 32'h5) begin
            n_err++;
            $display("FAIL control_out: got %h, want 5", hc_control);
        end
        mmio_wdata    = 64'hFFFF_FFFF_0000_0004;
        mmio_wr_valid = 1'b1;
        @(negedge clk);
        mmio_wr_valid = 1'b0;
        @(negedge clk);
        model_write(16'h0C, 64'hFFFF_FFFF_0000_0004);
        n_cmp++;
        if (hc_start !== 1'b0 || hc_control !== 32'h4) begin
            n_err++;
            $display("FAIL control_nostart: got start=%0b ctrl=%h, want start=0 ctrl=4", hc_start, hc_control);
        end
    endtask

    task automatic test_counters();
        logic        v;
        logic [8:0]  t;
        logic [63:0] d;
        longint unsigned c;
        cnt_event = 4'b0010;
        repeat (10) @(negedge clk);
        cnt_event = '0;
        m_cnt[1] += 10;
        single_read(16'h22, 9'd11, v, t, d);
        n_cmp++;
        if (v !== 1'b1 || d !== 64'd10) begin
            n_err++;
            $display("FAIL cnt1_ten: got valid=%0b data=%0d, want valid=1 data=10", v, d);
        end
        // Write lands on its stage-2 edge while the event is still high
        mmio_addr     = 16'h22;
        mmio_wdata    = {$urandom, $urandom};
        mmio_wr_valid = 1'b1;
        cnt_event     = 4'b0010;
        @(negedge clk);
        mmio_wr_valid = 1'b0;
        @(negedge clk);
        cnt_event = '0;
        m_cnt[1]  = 0;
        single_read(16'h22, 9'd12, v, t, d);
        n_cmp++;
        if (v !== 1'b1 || d !== 64'd0) begin
            n_err++;
            $display("FAIL cnt1_clear_vs_event: got valid=%0b data=%0d, want valid=1 data=0", v, d);
        end
        for (int k = 0; k < 40; k++) begin
            cnt_event = 4'($urandom_range(0, 15));
            @(negedge clk);
            for (int i = 0; i < NC; i++) if (cnt_event[i]) m_cnt[i]++;
        end
        cnt_event = '0;
        for (int i = 0; i < NC + 2; i++) begin
            logic        ev;
            logic [63:0] ed;
            model_read(16'(32 + 2*i), ev, ed);
            single_read(16'(32 + 2*i), 9'(20 + i), v, t, d);
            n_cmp++;
            if (v !== ev || t !== 9'(20 + i) || d !== ed) begin
                n_err++;
                $display("FAIL cnt_rand[%0d]: got valid=%0b tid=%0d data=%0d, want valid=%0b tid=%0d data=%0d",
                         i, v, t, d, ev, 20 + i, ed);
            end
        end
        // Read while counting: the response holds the value before the stage-2 edge increment
        c         = m_cnt[0];
        cnt_event = 4'b0001;
        single_read(16'h20, 9'd30, v, t, d);
        cnt_event = '0;
        m_cnt[0]  = c + 2;
        n_cmp++;
        if (d !== 64'(c + 1)) begin
            n_err++;
            $display("FAIL cnt_read_timing: got %0d, want %0d", d, c + 1);
        end
        single_read(16'h20, 9'd31, v, t, d);
        n_cmp++;
        if (d !== 64'(c + 2)) begin
            n_err++;
            $display("FAIL cnt_after_timing: got %0d, want %0d", d, c + 2);
        end
    endtask

    task automatic test_window();
        logic        v;
        logic [8:0]  t;
        logic [63:0] d;
        logic [15:0] waddr [5];
        logic [15:0] raddr [5];
        single_read(16'h80, 9'd40, v, t, d);
        n_cmp++;
        if (v !== 1'b0) begin
            n_err++;
            $display("FAIL out_of_window_rsp: got valid=%0b, want 0", v);
        end
        single_read(16'h30, 9'd41, v, t, d);
        n_cmp++;
        if (v !== 1'b1 || t !== 9'd41 || d !== 64'd0) begin
            n_err++;
            $display("FAIL counter8_read: got valid=%0b tid=%0d data=%h, want valid=1 tid=41 data=0", v, t, d);
        end
        single_write(16'h0A, 64'hA5A5_0000_1111_2222);
        // Write-ignore probes: out-of-window alias, buffer 4, reserved, DFH, STATUS
        waddr = '{16'h8A, 16'h50, 16'h06, 16'h00, 16'h0E};
        raddr = '{16'h0A, 16'h50, 16'h06, 16'h00, 16'h0E};
        for (int i = 0; i < 5; i++) begin
            logic        ev;
            logic [63:0] ed;
            single_write(waddr[i], {$urandom, $urandom});
            model_read(raddr[i], ev, ed);
            single_read(raddr[i], 9'(50 + i), v, t, d);
            n_cmp++;
            if (v !== ev || d !== ed) begin
                n_err++;
                $display("FAIL ignored_write[%0d]: got valid=%0b data=%h, want valid=%0b data=%h", i, v, d, ev, ed);
            end
        end
    endtask

    task automatic test_random();
        logic        ev [NRAND];
        logic [63:0] ed [NRAND];
        logic [8:0]  et [NRAND];
        logic        es [NRAND];
        hc_status = {$urandom, $urandom};
        m_status  = hc_status;
        for (int k = 0; k < NRAND + 2; k++) begin
            if (k >= 2) begin
                n_cmp++;
                if (mmio_rsp_valid !== ev[k-2] ||
                    (ev[k-2] && (mmio_rsp_tid !== et[k-2] || mmio_rsp_data !== ed[k-2]))) begin
                    n_err++;
                    $display("FAIL rand_rsp[%0d]: got valid=%0b tid=%0d data=%h, want valid=%0b tid=%0d data=%h",
                             k - 2, mmio_rsp_valid, mmio_rsp_tid, mmio_rsp_data, ev[k-2], et[k-2], ed[k-2]);
                end
                n_cmp++;
                if (hc_start !== es[k-2]) begin
                    n_err++;
                    $display("FAIL rand_start[%0d]: got %0b, want %0b", k - 2, hc_start, es[k-2]);
                end
            end
            if (k < NRAND) begin
                logic        rd, wr, v;
                logic [15:0] dw;
                logic [63:0] wd, rdat;
                logic [8:0]  tid;
                rd  = 1'($urandom_range(0, 1));
                wr  = 1'($urandom_range(0, 1));
                dw  = 16'($urandom_range(0, 127));
                if ($urandom_range(0, 9) == 0) dw = dw | 16'(($urandom_range(1, 15)) << 7);
                if ($urandom_range(0, 3) == 0) dw = 16'h0C;
                wd  = {$urandom, $urandom};
                tid = 9'($urandom_range(0, 511));
                model_read(dw, v, rdat);
                ev[k] = rd && v;
                ed[k] = rdat;
                et[k] = tid;
                es[k] = wr && (byte_off(dw) == 'h30) && (dw < 16'h80) && wd[0];
                if (wr) model_write(dw, wd);
                mmio_rd_valid = rd;
                mmio_wr_valid = wr;
                mmio_addr     = dw;
                mmio_wdata    = wd;
                mmio_tid      = tid;
            end else begin
                mmio_rd_valid = 1'b0;
                mmio_wr_valid = 1'b0;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (hc_control !== m_control || hc_dsm_base !== m_dsm[AW-1:0]) begin
            n_err++;
            $display("FAIL rand_scalar_out: got ctrl=%h dsm=%h, want ctrl=%h dsm=%h",
                     hc_control, hc_dsm_base, m_control, m_dsm[AW-1:0]);
        end
        for (int i = 0; i < NB; i++) begin
            n_cmp++;
            if (hc_buf_addr[i*AW +: AW] !== m_baddr[i][AW-1:0] || hc_buf_size[i*32 +: 32] !== m_bsize[i]) begin
                n_err++;
                $display("FAIL rand_buf_out[%0d]: got addr=%h size=%h, want addr=%h size=%h",
                         i, hc_buf_addr[i*AW +: AW], hc_buf_size[i*32 +: 32], m_baddr[i][AW-1:0], m_bsize[i]);
            end
        end
    endtask

    task automatic test_reset_midflight();
        logic        v;
        logic [8:0]  t;
        logic [63:0] d;
        single_write(16'h0C, 64'h3);
        single_write(16'h40, 64'hFFFF_FFC0);
        single_write(16'h40 + 16'h4, 64'hDEAD_BEC0);
        single_read(16'h00, 9'd3, v, t, d);
        mmio_addr     = 16'h0A;
        mmio_tid      = 9'd5;
        mmio_rd_valid = 1'b1;
        @(negedge clk);
        mmio_rd_valid = 1'b0;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (mmio_rsp_valid !== 1'b0 || mmio_rsp_tid !== '0 || mmio_rsp_data !== '0) begin
            n_err++;
            $display("FAIL midreset_rsp: got valid=%0b tid=%0d data=%h, want 0", mmio_rsp_valid, mmio_rsp_tid, mmio_rsp_data);
        end
        n_cmp++;
        if (hc_control !== '0 || hc_dsm_base !== '0 || hc_buf_addr !== '0 || hc_buf_size !== '0 || hc_start !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_outputs: got ctrl=%h dsm=%h baddr=%h bsize=%h start=%0b, want 0",
                     hc_control, hc_dsm_base, hc_buf_addr, hc_buf_size, hc_start);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (mmio_rsp_valid !== 1'b0) begin
                n_err++;
                $display("FAIL midreset_dropped[%0d]: got valid=%0b, want 0", k, mmio_rsp_valid);
            end
        end
        single_read(16'h0A, 9'd6, v, t, d);
        n_cmp++;
        if (v !== 1'b1 || t !== 9'd6 || d !== 64'd0) begin
            n_err++;
            $display("FAIL midreset_scratch: got valid=%0b tid=%0d data=%h, want valid=1 tid=6 data=0", v, t, d);
        end
    endtask

    initial begin
        test_reset();
        test_id_regs();
        test_buf_raw();
        test_control_start();
        test_counters();
        test_window();
        test_random();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
